// File: rtl/upg_arbiter_pkg.sv
// Shared types and constants for the programming-upgrade arbiter.
// Holds the mode encoding and the address bit that selects the memory bank.
package upg_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_PROG = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    localparam int BANK_BIT = 14;
    localparam int ADR_W    = 14;
    localparam int DAT_W    = 32;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/upg_arbiter_if.sv
// Programmer, CPU and memory write ports of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface upg_arbiter_if;
    import upg_arbiter_pkg::*;

    logic               upg_wen_i;
    logic [BANK_BIT:0]  upg_adr_i;
    logic [DAT_W-1:0]   upg_dat_i;
    logic               upg_done_i;
    logic               cpu_wen_i;
    logic [ADR_W-1:0]   cpu_adr_i;
    logic [DAT_W-1:0]   cpu_dat_i;
    logic               imem_wen_o;
    logic [ADR_W-1:0]   imem_adr_o;
    logic [DAT_W-1:0]   imem_dat_o;
    logic               dmem_wen_o;
    logic [ADR_W-1:0]   dmem_adr_o;
    logic [DAT_W-1:0]   dmem_dat_o;

    modport slave (
        input  upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        input  cpu_wen_i, cpu_adr_i, cpu_dat_i,
        output imem_wen_o, imem_adr_o, imem_dat_o,
        output dmem_wen_o, dmem_adr_o, dmem_dat_o
    );

    modport master (
        output upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        output cpu_wen_i, cpu_adr_i, cpu_dat_i,
        input  imem_wen_o, imem_adr_o, imem_dat_o,
        input  dmem_wen_o, dmem_adr_o, dmem_dat_o
    );

endinterface

// File: rtl/upg_arbiter_key_debounce.sv
// Synchronizes and debounces the program-mode key; press_o pulses for one
// cycle when the accepted level goes from 0 to 1.
module key_debounce #(
    parameter logic [19:0] DEB_CYC = 20'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic press_o
);
    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        press_q;
    logic [19:0] cnt_q;

    // Two-flop synchronizer for the asynchronous key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEB_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= 20'd0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= 20'd0;
            end else if (cnt_q >= DEB_CYC - 20'd1) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= 20'd0;
            end else begin
                cnt_q <= cnt_q + 20'd1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/upg_arbiter.sv
// Arbitrates the instruction/data memory write ports between the CPU and a
// UART programmer, sequencing CPU and programmer resets around a session.
module upg_arbiter
    import upg_arbiter_pkg::*;
#(
    parameter logic [19:0] DEB_CYC  = 20'd1000000,
    parameter logic [7:0]  HOLD_CYC = 8'd16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_key,
    upg_arbiter_if.slave  bus,
    output logic          upg_rst_o,
    output logic          cpu_rst_n_o,
    output logic [1:0]    mode_o,
    output logic [15:0]   word_cnt_o,
    output logic          prog_err_o
);
    state_e           state_q;
    logic [7:0]       hold_cnt_q;
    logic             upg_rst_q;
    logic             cpu_rst_n_q;
    logic             prog_err_q;
    logic [15:0]      word_cnt_q;
    logic             press_s;
    logic             upg_bank_s;
    logic [ADR_W-1:0] upg_word_s;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_key_debounce (
        .clk     (clk),
        .rst     (rst),
        .key_i   (prog_key),
        .press_o (press_s)
    );

    assign upg_bank_s = bus.upg_adr_i[BANK_BIT];
    assign upg_word_s = bus.upg_adr_i[BANK_BIT-1:0];

    // Mode sequencer; reset outputs are updated on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= HOLD_CYC;
            upg_rst_q   <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            word_cnt_q  <= 16'd0;
            prog_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (press_s) begin
                        state_q     <= ST_PROG;
                        word_cnt_q  <= 16'd0;
                        prog_err_q  <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                        upg_rst_q   <= 1'b0;
                    end
                end
                ST_PROG: begin
                    if (bus.upg_wen_i) begin
                        word_cnt_q <= sat_inc16(word_cnt_q);
                    end
                    // A key press aborts the session and takes priority over done.
                    if (press_s || bus.upg_done_i) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= HOLD_CYC;
                        upg_rst_q  <= 1'b1;
                        prog_err_q <= press_s;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_q     <= ST_RUN;
                        cpu_rst_n_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q     <= ST_HOLD;
                    hold_cnt_q  <= HOLD_CYC;
                    upg_rst_q   <= 1'b1;
                    cpu_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory port steering from the registered mode, no added latency.
    always_comb begin
        bus.imem_wen_o = 1'b0;
        bus.imem_adr_o = 14'd0;
        bus.imem_dat_o = 32'd0;
        bus.dmem_wen_o = 1'b0;
        bus.dmem_adr_o = 14'd0;
        bus.dmem_dat_o = 32'd0;
        case (state_q)
            ST_RUN: begin
                bus.dmem_wen_o = bus.cpu_wen_i;
                bus.dmem_adr_o = bus.cpu_adr_i;
                bus.dmem_dat_o = bus.cpu_dat_i;
            end
            ST_PROG: begin
                bus.imem_wen_o = bus.upg_wen_i & ~upg_bank_s;
                bus.imem_adr_o = upg_word_s;
                bus.imem_dat_o = bus.upg_dat_i;
                bus.dmem_wen_o = bus.upg_wen_i & upg_bank_s;
                bus.dmem_adr_o = upg_word_s;
                bus.dmem_dat_o = bus.upg_dat_i;
            end
            ST_HOLD: begin
                bus.dmem_wen_o = 1'b0;
            end
            default: begin
                bus.dmem_wen_o = 1'b0;
            end
        endcase
    end

    assign upg_rst_o   = upg_rst_q;
    assign cpu_rst_n_o = cpu_rst_n_q;
    assign mode_o      = state_q;
    assign word_cnt_o  = word_cnt_q;
    assign prog_err_o  = prog_err_q;

endmodule

// File: doc/upg_arbiter.md
UPG_ARBITER -- requirements
Module: upg_arbiter

Interface
REQ-001 Parameter DEB_CYC, default 20'd1000000, cycles a synchronized key level must stay stable before it is accepted.
REQ-002 Parameter HOLD_CYC, default 8'd16, cycles the CPU is held in reset after programming ends.
REQ-003 clk  in  1  single system clock; all logic in this one domain.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 prog_key  in  1  raw, asynchronous program-mode button.
REQ-006 upg_wen_i  in  1  UART programmer word-write strobe.
REQ-007 upg_adr_i  in  15  programmer address; bit 14 = bank (0 instruction, 1 data), bits 13:0 = word address.
REQ-008 upg_dat_i  in  32  programmer write data.
REQ-009 upg_done_i  in  1  programmer finished; level signal.
REQ-010 cpu_wen_i / cpu_adr_i / cpu_dat_i  in  1/14/32  CPU data-memory write port.
REQ-011 upg_rst_o  out  1  active-high reset to the programmer; held 1 outside PROG.
REQ-012 cpu_rst_n_o  out  1  active-low CPU reset.
REQ-013 imem_wen_o / imem_adr_o / imem_dat_o  out  1/14/32  instruction-memory write port.
REQ-014 dmem_wen_o / dmem_adr_o / dmem_dat_o  out  1/14/32  data-memory port.
REQ-015 mode_o  out  2  current state code.
REQ-016 word_cnt_o  out  16  count of words written in the last or current PROG session.
REQ-017 prog_err_o  out  1  sticky flag: last session was aborted.

Function
REQ-018 prog_key passes through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEB_CYC consecutive equal samples; press = debounced 0->1 edge, one cycle wide.
REQ-019 FSM states: RUN=2'b00, PROG=2'b01, HOLD=2'b10; the state is registered and mode_o equals the state code.
REQ-020 RUN: cpu_rst_n_o=1, upg_rst_o=1, imem_wen_o=0, dmem ports = cpu_* inputs unchanged.
REQ-021 RUN + press -> PROG next cycle; on entry word_cnt_o clears to 0 and prog_err_o clears to 0.
REQ-022 PROG: cpu_rst_n_o=0, upg_rst_o=0; imem_wen_o = upg_wen_i & ~upg_adr_i[14]; dmem_wen_o = upg_wen_i & upg_adr_i[14]; both adr outputs = upg_adr_i[13:0]; both dat outputs = upg_dat_i; cpu_wen_i is ignored.
REQ-023 Port muxing is combinational from the registered state: zero added latency on memory writes.
REQ-024 PROG: each cycle with upg_wen_i=1 increments word_cnt_o by 1; it saturates at 16'hFFFF.
REQ-025 PROG + upg_done_i=1 -> HOLD next cycle; a write in that same cycle is still forwarded and counted.
REQ-026 PROG + press (abort) -> HOLD and prog_err_o=1; abort wins over simultaneous upg_done_i.
REQ-027 HOLD: cpu_rst_n_o=0, upg_rst_o=1, all memory wen outputs 0; the hold counter loads HOLD_CYC on entry and decrements; at 0 -> RUN.
REQ-028 A press in HOLD is ignored.
REQ-029 A press in RUN with cpu_wen_i=1 in that cycle: the CPU write completes and the state change takes effect next cycle.

Reset
REQ-030 rst=0 asynchronously forces: state HOLD, hold counter=HOLD_CYC, cpu_rst_n_o=0, upg_rst_o=1, word_cnt_o=0, prog_err_o=0, synchronizer/debouncer=0.
REQ-031 After rst deasserts, the CPU is released HOLD_CYC+1 cycles later.
REQ-032 Reset asserted during PROG aborts the session without setting prog_err_o.

Structure
REQ-033 A shared package holds the state encoding (RUN/PROG/HOLD) and the constant BANK_BIT=14.
REQ-034 Debounce logic is sub-module key_debounce (clk, rst, key_i, press_o), parameterized by DEB_CYC.

Verification
REQ-035 Reset with HOLD_CYC=4 -> cpu_rst_n_o stays 0 for 5 cycles after rst rises, then 1; mode_o=00.
REQ-036 RUN, DEB_CYC=3, key high 4 cycles -> mode_o=01 and upg_rst_o=0; a 2-cycle glitch -> no change.
REQ-037 PROG, write adr 15'h0005 data 32'hDEADBEEF -> imem_wen_o=1, imem_adr_o=5; adr 15'h4005 -> dmem_wen_o=1, dmem_adr_o=5; word_cnt_o=2.
REQ-038 PROG, upg_done_i=1 with simultaneous write -> write forwarded, word_cnt_o incremented, HOLD, then RUN after HOLD_CYC cycles.
REQ-039 PROG, key press -> prog_err_o=1, HOLD, then RUN; a new PROG entry clears prog_err_o.
REQ-040 Force word_cnt_o to 16'hFFFF, then another write -> word_cnt_o stays 16'hFFFF.
